// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk_i cycles.
// One measurement per start_i; results held until the next completed measurement.
module clk_period_meter #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             meas_clk_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic meas_s1, meas_s2, meas_d;
  logic rise_stb, fall_stb;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meas_s1 <= 1'b0;
      meas_s2 <= 1'b0;
      meas_d  <= 1'b0;
    end else begin
      meas_s1 <= meas_clk_i;
      meas_s2 <= meas_s1;
      meas_d  <= meas_s2;
    end
  end

  assign rise_stb = meas_s2 & ~meas_d;
  assign fall_stb = ~meas_s2 & meas_d;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt, period_cnt, high_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             high_done;

  assign wait_nxt = wait_cnt + ONE;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      high_done  <= 1'b0;
      busy_o     <= 1'b0;
      valid_o    <= 1'b0;
      timeout_o  <= 1'b0;
      period_o   <= '0;
      high_o     <= '0;
    end else begin
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= ARM;
            wait_cnt <= '0;
            busy_o   <= 1'b1;
          end
        end
        ARM: begin
          if (rise_stb) begin
            state      <= MEASURE;
            period_cnt <= ONE;
            high_cnt   <= ONE;
            high_done  <= 1'b0;
          end else if (wait_nxt == TMO) begin
            // No edge ever arrived: report the full window, no high time.
            state     <= DONE;
            valid_o   <= 1'b1;
            timeout_o <= 1'b1;
            period_o  <= TMO;
            high_o    <= '0;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        MEASURE: begin
          // The closing edge takes priority over the threshold in the same cycle.
          if (rise_stb) begin
            state    <= DONE;
            valid_o  <= 1'b1;
            period_o <= period_cnt;
            high_o   <= high_cnt;
          end else if (period_cnt == TMO) begin
            state     <= DONE;
            valid_o   <= 1'b1;
            timeout_o <= 1'b1;
            period_o  <= TMO;
            high_o    <= high_cnt;
          end else begin
            period_cnt <= period_cnt + ONE;
            if (fall_stb) begin
              high_done <= 1'b1;
            end else if (!high_done && high_cnt != TMO) begin
              high_cnt <= high_cnt + ONE;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter, run with a reduced counter width
// so timeout scenarios stay short.
module tb_clk_period_meter;

  localparam int CW = 12;
  localparam int TO = 4095;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          meas_clk = 1'b0;
  logic          start = 1'b0;
  logic          busy_o, valid_o, timeout_o;
  logic [CW-1:0] period_o, high_o;

  int  checks = 0;
  int  errors = 0;

  bit  gen_en = 1'b0;
  bit  const_lvl = 1'b0;
  int  hi_len = 1;
  int  lo_len = 1;
  int  ph_cnt = 0;

  clk_period_meter #(.CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .meas_clk_i (meas_clk),
    .start_i    (start),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .timeout_o  (timeout_o),
    .period_o   (period_o),
    .high_o     (high_o)
  );

  always #5 clk = ~clk;

  // Measured-clock generator: exact high/low lengths in clk cycles.
  always @(negedge clk) begin
    if (!gen_en) begin
      meas_clk = const_lvl;
      ph_cnt   = 0;
    end else begin
      ph_cnt++;
      if (meas_clk && ph_cnt >= hi_len) begin
        meas_clk = 1'b0;
        ph_cnt   = 0;
      end else if (!meas_clk && ph_cnt >= lo_len) begin
        meas_clk = 1'b1;
        ph_cnt   = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc, output bit got,
                            output logic to, output logic [CW-1:0] per, output logic [CW-1:0] hi);
    got = 1'b0; cyc = 0; to = 1'b0; per = '0; hi = '0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (valid_o) begin
        got = 1'b1; to = timeout_o; per = period_o; hi = high_o;
      end
    end
  endtask

  task automatic run_periodic(input string name, input int h, input int l, input int exp_p,
                              input int exp_h, input logic exp_to);
    int cyc; bit got; logic to; logic [CW-1:0] per, hi;
    gen_en = 1'b0; const_lvl = 1'b0;
    repeat (5) @(negedge clk);
    hi_len = h; lo_len = l; gen_en = 1'b1;
    pulse_start();
    wait_valid(3 * TO, cyc, got, to, per, hi);
    checks++;
    if (!got) begin errors++; $display("FAIL %s_valid: no valid_o within %0d cycles", name, 3 * TO); end
    checks++;
    if (per !== CW'(exp_p)) begin errors++; $display("FAIL %s_period: got %0d expected %0d", name, per, exp_p); end
    checks++;
    if (hi !== CW'(exp_h)) begin errors++; $display("FAIL %s_high: got %0d expected %0d", name, hi, exp_h); end
    checks++;
    if (to !== exp_to) begin errors++; $display("FAIL %s_timeout: got %b expected %b", name, to, exp_to); end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL %s_done_1cyc: valid=%b busy=%b expected 0 0", name, valid_o, busy_o);
    end
    gen_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; const_lvl = 1'b1; start = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy_o, valid_o, timeout_o} !== 3'b000 || period_o !== '0 || high_o !== '0) begin
      errors++; $display("FAIL reset_outputs: busy=%b valid=%b to=%b per=%0d hi=%0d expected all 0",
                         busy_o, valid_o, timeout_o, period_o, high_o);
    end
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
        errors++; $display("FAIL reset_release_idle: busy=%b valid=%b expected 0 0", busy_o, valid_o);
      end
    end
    const_lvl = 1'b0;
  endtask

  task automatic test_stuck_low();
    int cyc; bit got; logic to; logic [CW-1:0] per, hi;
    gen_en = 1'b0; const_lvl = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_valid(TO + 50, cyc, got, to, per, hi);
    checks++;
    if (!got || cyc != TO) begin
      errors++; $display("FAIL stuck_low_latency: got=%b cycles=%0d expected 1 %0d", got, cyc, TO);
    end
    checks++;
    if (to !== 1'b1 || per !== CW'(TO) || hi !== '0) begin
      errors++; $display("FAIL stuck_low_result: to=%b per=%0d hi=%0d expected 1 %0d 0", to, per, hi, TO);
    end
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL stuck_low_pulse: valid=%b to=%b expected 0 0", valid_o, timeout_o);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit got; logic to; logic [CW-1:0] per, hi; int extra;
    gen_en = 1'b0; const_lvl = 1'b0;
    repeat (5) @(negedge clk);
    hi_len = 500; lo_len = 500; gen_en = 1'b1;
    pulse_start();
    repeat (200) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_high: got %b expected 1", busy_o); end
    pulse_start();
    wait_valid(3000, cyc, got, to, per, hi);
    checks++;
    if (!got || per !== CW'(1000) || hi !== CW'(500) || to !== 1'b0) begin
      errors++; $display("FAIL busy_result: got=%b per=%0d hi=%0d to=%b expected 1 1000 500 0", got, per, hi, to);
    end
    extra = 0;
    repeat (3000) begin
      @(negedge clk);
      if (valid_o) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_single_valid: extra valids %0d expected 0", extra); end
    gen_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int extra;
    gen_en = 1'b0; const_lvl = 1'b0;
    repeat (5) @(negedge clk);
    hi_len = 500; lo_len = 500;
    pulse_start();
    gen_en = 1'b1;
    repeat (800) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy_o, valid_o, timeout_o} !== 3'b000 || period_o !== '0 || high_o !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: busy=%b valid=%b to=%b per=%0d hi=%0d expected all 0",
                         busy_o, valid_o, timeout_o, period_o, high_o);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (3000) begin
      @(negedge clk);
      if (valid_o || busy_o) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL reset_mid_quiet: active cycles %0d expected 0", extra); end
    gen_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc; bit got; logic to; logic [CW-1:0] per, hi;
    gen_en = 1'b0; const_lvl = 1'b0;
    repeat (5) @(negedge clk);
    hi_len = 300; lo_len = 300; gen_en = 1'b1;
    pulse_start();
    wait_valid(3000, cyc, got, to, per, hi);
    checks++;
    if (!got || per !== CW'(600) || hi !== CW'(300) || to !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got=%b per=%0d hi=%0d to=%b expected 1 600 300 0", got, per, hi, to);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b expected 1", busy_o); end
    wait_valid(3000, cyc, got, to, per, hi);
    checks++;
    if (!got || per !== CW'(600) || hi !== CW'(300) || to !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got=%b per=%0d hi=%0d to=%b expected 1 600 300 0", got, per, hi, to);
    end
    gen_en = 1'b0;
  endtask

  initial begin
    test_reset();
    run_periodic("period_50khz", 1000, 1000, 2000, 1000, 1'b0);
    run_periodic("duty_30", 300, 700, 1000, 300, 1'b0);
    test_stuck_low();
    run_periodic("stuck_high", 5000, 50, TO, TO, 1'b1);
    run_periodic("edge_at_limit", 2000, 2095, TO, 2000, 1'b0);
    run_periodic("one_past_limit", 2000, 2096, TO, 2000, 1'b1);
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the period and high-time counters in clk_i cycles.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, setting the maximum clk_i cycles to wait for any expected edge; the value SHALL be at most 2^CNT_W-1.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port meas_clk_i, input, 1 bit: the slow clock under measurement, asynchronous to clk_i (for example the 50 kHz SCCB clock).
REQ-006 The block SHALL have port start_i, input, 1 bit: a one-cycle request to begin one measurement.
REQ-007 The block SHALL have port busy_o, output, 1 bit: high while a measurement is in progress.
REQ-008 The block SHALL have port valid_o, output, 1 bit: a one-cycle pulse marking a completed measurement.
REQ-009 The block SHALL have port timeout_o, output, 1 bit: a one-cycle pulse, concurrent with valid_o, marking a failed measurement.
REQ-010 The block SHALL have port period_o, output, CNT_W bits: the measured period in clk_i cycles.
REQ-011 The block SHALL have port high_o, output, CNT_W bits: the measured high time in clk_i cycles.

Function
REQ-012 meas_clk_i SHALL pass through a two-flop synchronizer, followed by one delay flop for edge detection.
REQ-013 A rising-edge strobe SHALL be asserted for one cycle when the synchronized value is 1 and the delayed value is 0; a falling-edge strobe SHALL use the opposite condition.
REQ-014 The FSM states SHALL be IDLE, ARM, MEASURE and DONE.
REQ-015 IDLE: on start_i=1, the FSM SHALL go to ARM and clear the wait counter; start_i SHALL be ignored in every other state.
REQ-016 ARM: on a rising-edge strobe, the FSM SHALL go to MEASURE with period and high counters set to 1.
REQ-017 ARM: if the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with the timeout flag set.
REQ-018 MEASURE: the period counter SHALL increment every cycle.
REQ-019 MEASURE: the high counter SHALL increment every cycle until the first falling-edge strobe, then hold.
REQ-020 MEASURE: on the next rising-edge strobe, the FSM SHALL latch period_o = period counter and high_o = high counter, then go to DONE.
REQ-021 The result SHALL be the exact clk_i cycle count between consecutive detected rising edges; synchronizer delay cancels and SHALL NOT be compensated.
REQ-022 MEASURE: if the period counter reaches TIMEOUT_CYCLES before a rising edge, the FSM SHALL go to DONE with timeout set, period_o = TIMEOUT_CYCLES, and high_o = the high count so far, saturated at TIMEOUT_CYCLES.
REQ-023 If a rising edge and the timeout threshold occur in the same cycle, the edge SHALL win and the result SHALL be valid with no timeout.
REQ-024 The counters SHALL never wrap; they SHALL saturate at TIMEOUT_CYCLES.
REQ-025 DONE: valid_o SHALL pulse for exactly one cycle, timeout_o SHALL pulse in that same cycle if the timeout flag is set, and the FSM SHALL return to IDLE next cycle.
REQ-026 busy_o SHALL be 1 in ARM, MEASURE and DONE, and 0 in IDLE.
REQ-027 A new start_i SHALL be accepted in the first IDLE cycle after DONE.
REQ-028 period_o and high_o SHALL hold their last latched values until the next DONE.

Reset
REQ-029 While reset_i=1, the block SHALL hold: FSM=IDLE, all counters=0, synchronizer flops=0, busy_o=0, valid_o=0, timeout_o=0, period_o=0, high_o=0.
REQ-030 Asserting reset_i mid-measurement SHALL abort immediately with no valid_o pulse; after release, the block SHALL wait for a fresh start_i.
REQ-031 The first edge-detect cycle after reset release SHALL NOT report a spurious rising edge, even if meas_clk_i is high, because the delay flop resets to 0 and the synchronized value starts at 0.

Verification
REQ-032 With meas_clk_i toggling every 1000 clk_i cycles (50 kHz from 100 MHz), pulse start_i -> one valid_o with period_o=2000, high_o=1000, timeout_o=0.
REQ-033 With meas_clk_i high for 300 cycles and low for 700 cycles, pulse start_i -> period_o=1000, high_o=300.
REQ-034 With meas_clk_i stuck low, pulse start_i -> valid_o and timeout_o pulse together 65535 cycles after leaving IDLE, period_o=65535.
REQ-035 With meas_clk_i high for 70000 cycles after the first rising edge -> timeout, period_o=65535, high_o=65535.
REQ-036 Pulse start_i again while busy_o=1 -> ignored, exactly one valid_o; assert reset_i during MEASURE -> outputs 0 immediately, no valid_o.
REQ-037 Two back-to-back measurements with start_i asserted in the cycle after valid_o -> both accepted with identical results.
